// File: rtl/tile_io_exerciser_if.sv
// Bundle between the tile I/O exerciser and its driver: run control,
// tile stimulus/response bytes and run status/result.
interface tile_io_exerciser_if;
  logic        start;
  logic [7:0]  pattern_count;
  logic [2:0]  settle;
  logic [7:0]  dut_uo;
  logic [7:0]  dut_ui;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [7:0]  vec_idx;

  // Exerciser side
  modport slave (
    input  start, pattern_count, settle, dut_uo,
    output dut_ui, busy, done, signature, vec_idx
  );

  // Controller side
  modport master (
    output start, pattern_count, settle, dut_uo,
    input  dut_ui, busy, done, signature, vec_idx
  );
endinterface

// File: rtl/tile_io_exerciser.sv
// Tile I/O exerciser: drives a sequence of stimulus bytes into a tile,
// waits a programmable settle time per vector, and compresses the tile
// response into a 16-bit MISR signature.
// Build option: define TILE_EXERCISER_LFSR_EN to source stimulus from an
// 8-bit Fibonacci LFSR; otherwise vector i is simply the index i.
module tile_io_exerciser #(
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter logic [15:0] SIG_INIT  = 16'hFFFF
) (
  input logic           clk,
  input logic           rst_n,
  tile_io_exerciser_if.slave io
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  state;
  logic [7:0]  count_q;
  logic [2:0]  settle_q;
  logic [2:0]  cnt;
  logic [7:0]  dut_ui_q;
  logic [7:0]  vec_idx_q;
  logic [15:0] sig_q;

  logic [7:0]  first_vec;
  logic [7:0]  next_vec;
  logic        last_vec;
  logic        fb;

`ifdef TILE_EXERCISER_LFSR_EN
  logic [7:0] lfsr_q;

  assign first_vec = LFSR_SEED;
  assign next_vec  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // LFSR reloads at every accepted start and steps once per vector advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (state == IDLE && io.start) begin
      lfsr_q <= LFSR_SEED;
    end else if (state == SAMPLE && !last_vec) begin
      lfsr_q <= next_vec;
    end
  end
`else
  assign first_vec = '0;
  assign next_vec  = vec_idx_q + 8'd1;
`endif

  // count of 0 wraps to 255 here, giving a 256-vector run
  assign last_vec = (vec_idx_q == count_q - 8'd1);
  assign fb       = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];

  // Run sequencer: latch config, step vectors, fold responses into the MISR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count_q   <= '0;
      settle_q  <= '0;
      cnt       <= '0;
      dut_ui_q  <= '0;
      vec_idx_q <= '0;
      sig_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          dut_ui_q <= '0;
          if (io.start) begin
            count_q   <= io.pattern_count;
            settle_q  <= io.settle;
            cnt       <= io.settle;
            vec_idx_q <= '0;
            sig_q     <= SIG_INIT;
            dut_ui_q  <= first_vec;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        SAMPLE: begin
          sig_q <= {sig_q[14:0], fb} ^ {8'h00, io.dut_uo};
          if (last_vec) begin
            dut_ui_q <= '0;
            state    <= DONE;
          end else begin
            vec_idx_q <= vec_idx_q + 8'd1;
            dut_ui_q  <= next_vec;
            cnt       <= settle_q;
            state     <= SETTLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign io.dut_ui    = dut_ui_q;
  assign io.vec_idx   = vec_idx_q;
  assign io.signature = sig_q;
  assign io.busy      = (state == SETTLE) || (state == SAMPLE);
  assign io.done      = (state == DONE);

endmodule

// File: tb/tb_tile_io_exerciser.sv
// Self-checking bench for tile_io_exerciser. The tile is modelled as a
// loopback with a per-run XOR mask; expected stimulus, timing and signature
// are derived per run from the vector list and the per-vector period.
module tb_tile_io_exerciser;

  logic       clk;
  logic       rst_n;
  logic [7:0] uo_mask;
  logic [15:0] sig_model;

  int unsigned n_tests;
  int unsigned n_fail;

  tile_io_exerciser_if bus ();

  assign bus.dut_uo = bus.dut_ui ^ uo_mask;

  tile_io_exerciser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(bus.busy),      32'd0);
    check({tag, "_done"},    32'(bus.done),      32'd0);
    check({tag, "_dut_ui"},  32'(bus.dut_ui),    32'd0);
    check({tag, "_vec_idx"}, 32'(bus.vec_idx),   32'd0);
    check({tag, "_sig"},     32'(bus.signature), 32'd0);
  endtask

  // Stimulus list a run of n vectors is expected to drive
  task automatic build_vectors(output logic [7:0] vecs [256]);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < 256; i++) begin
`ifdef TILE_EXERCISER_LFSR_EN
      vecs[i] = v;
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
      vecs[i] = i[7:0];
`endif
    end
  endtask

  // Called at #1 after a posedge while the DUT is idle; returns at #1 in
  // the idle cycle that follows the done pulse.
  task automatic run_vectors(input int unsigned n_raw, input int unsigned s,
                             input logic [7:0] mask, input bit hold, input bit churn);
    logic [7:0]  vecs [256];
    logic [15:0] sig;
    logic [7:0]  resp;
    int unsigned n;
    int unsigned per;
    int unsigned total;
    n     = (n_raw == 0) ? 256 : n_raw;
    per   = s + 2;
    total = n * per;
    build_vectors(vecs);
    sig = 16'hFFFF;
    for (int i = 0; i < int'(n); i++) begin
      resp = vecs[i] ^ mask;
      sig  = {sig[14:0], sig[15] ^ sig[14] ^ sig[12] ^ sig[3]} ^ {8'h00, resp};
    end

    check("pre_busy", 32'(bus.busy), 32'd0);
    check("pre_sig_hold", 32'(bus.signature), 32'(sig_model));

    uo_mask           = mask;
    bus.start         = 1'b1;
    bus.pattern_count = n_raw[7:0];
    bus.settle        = s[2:0];

    for (int unsigned k = 0; k <= total; k++) begin
      @(posedge clk);
      #1;
      if (k < total) begin
        check("run_busy",    32'(bus.busy),    32'd1);
        check("run_done",    32'(bus.done),    32'd0);
        check("run_dut_ui",  32'(bus.dut_ui),  32'(vecs[k / per]));
        check("run_vec_idx", 32'(bus.vec_idx), k / per);
        bus.start = hold ? 1'b1 : 1'($urandom);
        if (churn) begin
          bus.pattern_count = 8'($urandom);
          bus.settle        = 3'($urandom);
        end
      end else begin
        check("end_busy",    32'(bus.busy),      32'd0);
        check("end_done",    32'(bus.done),      32'd1);
        check("end_dut_ui",  32'(bus.dut_ui),    32'd0);
        check("end_vec_idx", 32'(bus.vec_idx),   n - 1);
        check("end_sig",     32'(bus.signature), 32'(sig));
        bus.start = hold;
      end
    end

    @(posedge clk);
    #1;
    check("idle_busy",    32'(bus.busy),      32'd0);
    check("idle_done",    32'(bus.done),      32'd0);
    check("idle_dut_ui",  32'(bus.dut_ui),    32'd0);
    check("idle_vec_idx", 32'(bus.vec_idx),   n - 1);
    check("idle_sig",     32'(bus.signature), 32'(sig));
    sig_model = sig;
  endtask

  initial begin
    int unsigned s_rst;
    n_tests           = 0;
    n_fail            = 0;
    sig_model         = 16'h0000;
    uo_mask           = 8'h00;
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.pattern_count = 8'd0;
    bus.settle        = 3'd0;

    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("post_rel");

    // single vector, no settle, pure loopback
    run_vectors(1, 0, 8'h00, 1'b0, 1'b0);
`ifndef TILE_EXERCISER_LFSR_EN
    check("single_sig_const", 32'(bus.signature), 32'h0000_FFFE);
`endif

    run_vectors(3, 1, 8'($urandom), 1'b0, 1'b0);

    // full 256-vector run with longest settle
    run_vectors(0, 7, 8'($urandom), 1'b0, 1'b0);

    // configuration churn during a run must not disturb it
    run_vectors(6, 2, 8'($urandom), 1'b0, 1'b1);

    // start held high: back-to-back runs separated by one idle cycle
    run_vectors(2, 0, 8'($urandom), 1'b1, 1'b0);
    run_vectors(2, 0, 8'($urandom), 1'b1, 1'b0);
    run_vectors(2, 0, 8'($urandom), 1'b1, 1'b0);
    run_vectors(2, 0, 8'($urandom), 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_vectors($urandom_range(20, 1), $urandom_range(7, 0), 8'($urandom),
                  1'b0, 1'($urandom));
    end

    // asynchronous reset in the middle of vector 5 of a 10-vector run
    s_rst             = $urandom_range(7, 0);
    uo_mask           = 8'($urandom);
    bus.start         = 1'b1;
    bus.pattern_count = 8'd10;
    bus.settle        = 3'(s_rst);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5 * (s_rst + 2)) @(posedge clk);
    #1;
    check("pre_rst_vec_idx", 32'(bus.vec_idx), 32'd5);
    check("pre_rst_busy",    32'(bus.busy),    32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("rst_hold_done", 32'(bus.done), 32'd0);
      check("rst_hold_busy", 32'(bus.busy), 32'd0);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    sig_model = 16'h0000;
    @(posedge clk);
    #1;
    check("rst_rel_done", 32'(bus.done), 32'd0);
    run_vectors(10, s_rst, 8'($urandom), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
